fetch_unit: RTL and testbench



---
 rtl/fetch_unit_if.sv | 39 +++
 rtl/fetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: control-unit command inputs, instruction-memory handshake and
// fetch-stage status outputs, bundled for the fetch_unit port list.
interface fetch_unit_if #(
  parameter int unsigned XLEN = 64
);
  // control unit commands and ALU results
  logic            pc_write;
  logic            pc_write_cond;
  logic            branch_op;
  logic            pc_src;
  logic            load_ir;
  logic            alu_zero;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] alu_out;
  // instruction memory handshake
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  // fetch stage status
  logic [XLEN-1:0] pc;
  logic [31:0]     instruction;
  logic            fetch_busy;
  logic            fetch_err;

  // fetch unit side
  modport master (
    input  pc_write, pc_write_cond, branch_op, pc_src, load_ir, alu_zero,
    input  alu_result, alu_out, imem_ack, imem_rdata,
    output imem_req, imem_addr, pc, instruction, fetch_busy, fetch_err
  );

  // control unit / instruction memory side
  modport slave (
    output pc_write, pc_write_cond, branch_op, pc_src, load_ir, alu_zero,
    output alu_result, alu_out, imem_ack, imem_rdata,
    input  imem_req, imem_addr, pc, instruction, fetch_busy, fetch_err
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC register plus instruction-fetch FSM (IDLE/WAIT) feeding the
// multicycle control unit. PC writes are honoured in any state and never move
// the address of an outstanding fetch; misaligned fetches return a zero word
// and a one-cycle fetch_err pulse.
// Optional feature: define FETCH_TIMEOUT_EN to abort a fetch after ACK_TIMEOUT
// WAIT cycles without imem_ack (instruction cleared, fetch_err pulsed).
module fetch_unit #(
  parameter int unsigned     XLEN        = 64,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int unsigned     ACK_TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Reject out-of-range timeout at elaboration
  if (ACK_TIMEOUT == 0 || ACK_TIMEOUT > 255) begin : g_bad_timeout
    $error("fetch_unit: ACK_TIMEOUT must be in 1..255");
  end

  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            err_q, err_d;
  logic            pc_we_c;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;
`endif

  // PC write enable: unconditional, or branch taken (BEQ/BNE via branch_op)
  assign pc_we_c = bus.pc_write | (bus.pc_write_cond & (bus.alu_zero ^ bus.branch_op));

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      err_q   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state and register-update logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    req_d   = req_q;
    addr_d  = addr_q;
    err_d   = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif

    if (pc_we_c) begin
      pc_d = bus.pc_src ? bus.alu_out : bus.alu_result;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.load_ir) begin
          if (pc_q[1:0] == 2'b00) begin
            // fetch from the PC as it was before any same-edge update
            addr_d  = pc_q;
            req_d   = 1'b1;
            state_d = ST_WAIT;
`ifdef FETCH_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            instr_d = '0;
            err_d   = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (bus.imem_ack) begin
          // ack beats a coincident timeout
          instr_d = bus.imem_rdata;
          req_d   = 1'b0;
          state_d = ST_IDLE;
`ifdef FETCH_TIMEOUT_EN
        end else if (cnt_q == TO_LAST) begin
          instr_d = '0;
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  assign bus.pc          = pc_q;
  assign bus.instruction = instr_q;
  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.fetch_err   = err_q;
  assign bus.fetch_busy  = (state_q == ST_WAIT);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard-driven bench for fetch_unit. Expected fetch
// addresses and captured instruction words are queued when stimulus is driven
// and popped when the DUT presents them.
module tb_fetch_unit;
  localparam int unsigned XLEN = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(XLEN)) bus ();

  fetch_unit #(
    .XLEN       (XLEN),
    .RESET_PC   ('0),
    .ACK_TIMEOUT(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0]     exp_instr_q[$];
  logic [XLEN-1:0] exp_addr_q[$];

  // advance one cycle and settle just after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.branch_op     = 1'b0;
    bus.pc_src        = 1'b0;
    bus.load_ir       = 1'b0;
    bus.alu_zero      = 1'b0;
    bus.alu_result    = '0;
    bus.alu_out       = '0;
    bus.imem_ack      = 1'b0;
    bus.imem_rdata    = '0;
  endtask

  task automatic set_pc(input logic [XLEN-1:0] v);
    bus.pc_write   = 1'b1;
    bus.pc_src     = 1'b0;
    bus.alu_result = v;
    step();
    bus.pc_write   = 1'b0;
    checks++;
    if (bus.pc !== v) begin
      errors++;
      $display("FAIL set_pc: pc=%h expected %h", bus.pc, v);
    end
  endtask

  task automatic test_reset();
    logic [31:0] e;
    rst = 1'b0;
    clear_inputs();
    repeat (2) step();
    e = 32'h0;
    exp_instr_q.push_back(e);
    checks++;
    if (bus.pc !== '0) begin errors++; $display("FAIL reset_pc: got %h expected 0", bus.pc); end
    checks++;
    if (bus.instruction !== exp_instr_q.pop_front()) begin
      errors++; $display("FAIL reset_instr: got %h expected 0", bus.instruction);
    end
    checks++;
    if (bus.imem_req !== 1'b0 || bus.imem_addr !== '0) begin
      errors++; $display("FAIL reset_req: req=%b addr=%h expected 0/0", bus.imem_req, bus.imem_addr);
    end
    checks++;
    if (bus.fetch_busy !== 1'b0 || bus.fetch_err !== 1'b0) begin
      errors++; $display("FAIL reset_flags: busy=%b err=%b expected 0/0", bus.fetch_busy, bus.fetch_err);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_first_fetch();
    int busy_cnt;
    bus.load_ir    = 1'b1;
    bus.pc_write   = 1'b1;
    bus.alu_result = 64'h4;
    exp_addr_q.push_back(64'h0);
    step();
    bus.load_ir  = 1'b0;
    bus.pc_write = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h0 || bus.pc !== 64'h4) begin
      errors++;
      $display("FAIL first_issue: req=%b addr=%h pc=%h expected 1/0/4", bus.imem_req, bus.imem_addr, bus.pc);
    end
    busy_cnt = bus.fetch_busy ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.fetch_busy) busy_cnt++;
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h00A00093;
    exp_instr_q.push_back(32'h00A00093);
    checks++;
    if (bus.imem_addr !== exp_addr_q.pop_front()) begin
      errors++; $display("FAIL first_addr: addr=%h expected 0", bus.imem_addr);
    end
    step();
    bus.imem_ack = 1'b0;
    if (bus.fetch_busy) busy_cnt++;
    checks++;
    if (bus.instruction !== exp_instr_q.pop_front()) begin
      errors++; $display("FAIL first_instr: got %h expected 00a00093", bus.instruction);
    end
    checks++;
    if (busy_cnt != 4 || bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL first_busy: busy cycles=%0d req=%b expected 4/0", busy_cnt, bus.imem_req);
    end
    // stray ack while idle must not touch the instruction register
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEADBEEF;
    step();
    bus.imem_ack = 1'b0;
    checks++;
    if (bus.instruction !== 32'h00A00093) begin
      errors++; $display("FAIL idle_ack: got %h expected 00a00093", bus.instruction);
    end
  endtask

  task automatic test_branch();
    // BEQ taken via alu_out
    bus.pc_write_cond = 1'b1;
    bus.branch_op     = 1'b0;
    bus.alu_zero      = 1'b1;
    bus.pc_src        = 1'b1;
    bus.alu_out       = 64'h40;
    bus.alu_result    = 64'h99;
    step();
    checks++;
    if (bus.pc !== 64'h40) begin errors++; $display("FAIL beq_taken: pc=%h expected 40", bus.pc); end
    // BEQ not taken
    bus.alu_zero = 1'b0;
    bus.alu_out  = 64'h80;
    step();
    checks++;
    if (bus.pc !== 64'h40) begin errors++; $display("FAIL beq_not_taken: pc=%h expected 40", bus.pc); end
    // BNE taken from a different PC
    bus.pc_write_cond = 1'b0;
    set_pc(64'h10);
    bus.pc_write_cond = 1'b1;
    bus.branch_op     = 1'b1;
    bus.alu_zero      = 1'b0;
    bus.pc_src        = 1'b1;
    bus.alu_out       = 64'h40;
    step();
    checks++;
    if (bus.pc !== 64'h40) begin errors++; $display("FAIL bne_taken: pc=%h expected 40", bus.pc); end
    // BNE not taken
    bus.alu_zero = 1'b1;
    bus.alu_out  = 64'h88;
    step();
    checks++;
    if (bus.pc !== 64'h40) begin errors++; $display("FAIL bne_not_taken: pc=%h expected 40", bus.pc); end
    // conditional write selecting alu_result
    bus.alu_zero   = 1'b0;
    bus.pc_src     = 1'b0;
    bus.alu_result = 64'h44;
    step();
    checks++;
    if (bus.pc !== 64'h44) begin errors++; $display("FAIL cond_alu_result: pc=%h expected 44", bus.pc); end
    clear_inputs();
  endtask

  task automatic test_misalign();
    set_pc(64'h6);
    bus.load_ir = 1'b1;
    exp_instr_q.push_back(32'h0);
    step();
    bus.load_ir = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.fetch_busy !== 1'b0) begin
      errors++; $display("FAIL misalign_req: req=%b busy=%b expected 0/0", bus.imem_req, bus.fetch_busy);
    end
    checks++;
    if (bus.instruction !== exp_instr_q.pop_front() || bus.fetch_err !== 1'b1) begin
      errors++; $display("FAIL misalign_err: instr=%h err=%b expected 0/1", bus.instruction, bus.fetch_err);
    end
    step();
    checks++;
    if (bus.fetch_err !== 1'b0) begin errors++; $display("FAIL misalign_pulse: err=%b expected 0", bus.fetch_err); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    set_pc(64'h100);
    bus.load_ir = 1'b1;
    exp_addr_q.push_back(64'h100);
    step();
    // load_ir again plus a PC write while the fetch is outstanding
    bus.load_ir    = 1'b1;
    bus.pc_write   = 1'b1;
    bus.alu_result = 64'h200;
    step();
    bus.load_ir  = 1'b0;
    bus.pc_write = 1'b0;
    checks++;
    if (bus.imem_addr !== 64'h100 || bus.pc !== 64'h200 || bus.fetch_busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_pc_write: addr=%h pc=%h busy=%b expected 100/200/1", bus.imem_addr, bus.pc, bus.fetch_busy);
    end
    step();
    d = $urandom();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = d;
    exp_instr_q.push_back(d);
    checks++;
    if (bus.imem_addr !== exp_addr_q.pop_front()) begin
      errors++; $display("FAIL wait_addr: addr=%h expected 100", bus.imem_addr);
    end
    step();
    bus.imem_ack = 1'b0;
    checks++;
    if (bus.instruction !== exp_instr_q.pop_front() || bus.fetch_busy !== 1'b0) begin
      errors++; $display("FAIL b2b_capture: instr=%h busy=%b expected %h/0", bus.instruction, bus.fetch_busy, d);
    end
    step();
    checks++;
    if (bus.imem_req !== 1'b0 || bus.fetch_busy !== 1'b0) begin
      errors++; $display("FAIL no_queue: req=%b busy=%b expected 0/0", bus.imem_req, bus.fetch_busy);
    end
  endtask

  task automatic test_reset_in_wait();
    set_pc(64'h300);
    bus.load_ir = 1'b1;
    step();
    bus.load_ir = 1'b0;
    step();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.fetch_busy !== 1'b0) begin
      errors++; $display("FAIL rst_wait_req: req=%b busy=%b expected 0/0", bus.imem_req, bus.fetch_busy);
    end
    checks++;
    if (bus.pc !== '0 || bus.instruction !== 32'h0) begin
      errors++; $display("FAIL rst_wait_state: pc=%h instr=%h expected 0/0", bus.pc, bus.instruction);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h12345678;
    step();
    bus.imem_ack = 1'b0;
    checks++;
    if (bus.instruction !== 32'h0) begin
      errors++; $display("FAIL rst_wait_ack: instr=%h expected 0", bus.instruction);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    // preload a nonzero instruction so a clear is observable
    set_pc(64'h8);
    d = 32'hCAFEF00D;
    bus.load_ir = 1'b1;
    step();
    bus.load_ir    = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = d;
    step();
    bus.imem_ack = 1'b0;
    checks++;
    if (bus.instruction !== d) begin errors++; $display("FAIL preload: instr=%h expected %h", bus.instruction, d); end
`ifdef FETCH_TIMEOUT_EN
    // no ack: request held for 15 WAIT cycles, then aborted
    bus.load_ir = 1'b1;
    step();
    bus.load_ir = 1'b0;
    for (int i = 1; i < 15; i++) begin
      step();
      checks++;
      if (bus.imem_req !== 1'b1 || bus.fetch_err !== 1'b0) begin
        errors++; $display("FAIL to_hold cycle %0d: req=%b err=%b expected 1/0", i, bus.imem_req, bus.fetch_err);
      end
    end
    exp_instr_q.push_back(32'h0);
    step();
    checks++;
    if (bus.imem_req !== 1'b0 || bus.fetch_err !== 1'b1 || bus.instruction !== exp_instr_q.pop_front()) begin
      errors++;
      $display("FAIL to_abort: req=%b err=%b instr=%h expected 0/1/0", bus.imem_req, bus.fetch_err, bus.instruction);
    end
    step();
    checks++;
    if (bus.fetch_err !== 1'b0) begin errors++; $display("FAIL to_pulse: err=%b expected 0", bus.fetch_err); end
    // ack on the 15th WAIT cycle wins over the timeout
    bus.load_ir = 1'b1;
    step();
    bus.load_ir = 1'b0;
    repeat (14) step();
    d = $urandom();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = d;
    exp_instr_q.push_back(d);
    step();
    bus.imem_ack = 1'b0;
    checks++;
    if (bus.instruction !== exp_instr_q.pop_front() || bus.fetch_err !== 1'b0 || bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL to_ack_wins: instr=%h err=%b req=%b expected %h/0/0", bus.instruction, bus.fetch_err, bus.imem_req, d);
    end
`else
    // without the timeout a fetch waits indefinitely for ack
    bus.load_ir = 1'b1;
    step();
    bus.load_ir = 1'b0;
    repeat (30) step();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.fetch_busy !== 1'b1 || bus.fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout: req=%b busy=%b err=%b expected 1/1/0", bus.imem_req, bus.fetch_busy, bus.fetch_err);
    end
    d = $urandom();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = d;
    exp_instr_q.push_back(d);
    step();
    bus.imem_ack = 1'b0;
    checks++;
    if (bus.instruction !== exp_instr_q.pop_front() || bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL late_ack: instr=%h req=%b expected %h/0", bus.instruction, bus.imem_req, d);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_branch();
    test_misalign();
    test_back_to_back();
    test_reset_in_wait();
    test_timeout();
    checks++;
    if (exp_instr_q.size() != 0 || exp_addr_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: instr_q=%0d addr_q=%0d expected 0/0", exp_instr_q.size(), exp_addr_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global run bound
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
